// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: queues keyboard direction commands and applies one per game tick.
// Define KEY_CMD_REVERSE_BLOCK_EN to discard popped directions that reverse cur_dir.
module key_cmd_scheduler #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [8:0]                last_change,
  input  logic                      key_down,
  input  logic                      tick,
  output logic [1:0]                cur_dir,
  output logic                      step,
  output logic [1:0]                state,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      overflow
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;
  state_t st, st_nxt;
  logic [1:0] mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] code;
  logic [1:0] dir, tail, head;
  logic acc, is_dir, is_space, empty, full, push_req, do_push, pop, apply;
  always_comb begin
    code = last_change[7:0];
    is_dir = code == 8'h1D || code == 8'h1B || code == 8'h1C || code == 8'h23;
    is_space = code == 8'h29;
    dir = code == 8'h1D ? 2'd0 : code == 8'h1B ? 2'd1 : code == 8'h1C ? 2'd2 : 2'd3;
    empty = q_count == '0;
    full = q_count == (AW+1)'(QDEPTH);
    head = mem[rd_ptr];
    // with an empty queue the duplicate filter compares against the applied direction
    tail = empty ? cur_dir : mem[wr_ptr - 1'b1];
  end
`ifdef KEY_CMD_REVERSE_BLOCK_EN
  assign apply = head != {cur_dir[1], ~cur_dir[0]};
`else
  assign apply = 1'b1;
`endif
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= st_nxt;
  always_comb
    st_nxt = !acc ? st :
             (st == IDLE && is_dir) ? RUN :
             (st == RUN && is_space) ? PAUSED :
             (st == PAUSED && is_space) ? RUN : st;
  always_comb begin
    acc = key_valid & key_down & ~last_change[8];
    pop = tick & (st == RUN) & ~empty;
    push_req = acc & is_dir & (dir != tail);
    // a full queue still accepts a push when the same edge pops
    do_push = push_req & (~full | pop);
    state = st;
  end
  always_ff @(posedge clk)
    if (do_push && !rst) mem[wr_ptr] <= dir;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_count <= '0;
      cur_dir <= 2'd0;
      step <= 1'b0;
      overflow <= 1'b0;
    end else begin
      step <= tick & (st == RUN);
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop && apply) cur_dir <= head;
      q_count <= q_count + (AW+1)'(do_push) - (AW+1)'(pop);
      if (push_req && !do_push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb_key_cmd_scheduler: directed and random checks of key_cmd_scheduler against a queue-based model.
module tb_key_cmd_scheduler;
  localparam int QD = 4;
`ifdef KEY_CMD_REVERSE_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, key_valid = 1'b0, key_down = 1'b0, tick = 1'b0;
  logic [8:0] last_change = '0;
  logic [1:0] cur_dir, state;
  logic step, overflow;
  logic [$clog2(QD):0] q_count;
  int checks = 0, failures = 0;
  logic [1:0] mq[$];
  logic [1:0] m_dir = 0, m_state = 0;
  logic m_step = 0, m_ovf = 0;

  key_cmd_scheduler #(.QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .tick(tick), .cur_dir(cur_dir), .step(step),
    .state(state), .q_count(q_count), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic kv, input logic [8:0] lc, input logic kd, input logic tk);
    logic acc, isdir, isspace, pop;
    logic [1:0] d, tl, h;
    int n;
    if (r) begin
      mq.delete();
      m_dir = 0; m_step = 0; m_state = 0; m_ovf = 0;
      return;
    end
    acc = kv && kd && !lc[8];
    isdir = 1'b1;
    case (lc[7:0])
      8'h1D: d = 0;
      8'h1B: d = 1;
      8'h1C: d = 2;
      8'h23: d = 3;
      default: begin d = 0; isdir = 1'b0; end
    endcase
    isspace = lc[7:0] == 8'h29;
    n = mq.size();
    tl = n > 0 ? mq[$] : m_dir;
    pop = tk && m_state == 1 && n > 0;
    m_step = tk && m_state == 1;
    if (pop) begin
      h = mq.pop_front();
      if (!(BLK && h / 2 == m_dir / 2 && h != m_dir)) m_dir = h;
    end
    if (acc && isdir && d != tl) begin
      if (n < QD || pop) mq.push_back(d);
      else m_ovf = 1;
    end
    if (acc && isdir && m_state == 0) m_state = 1;
    else if (acc && isspace && m_state == 1) m_state = 2;
    else if (acc && isspace && m_state == 2) m_state = 1;
  endtask

  task automatic cyc(input logic r, input logic kv, input logic [8:0] lc, input logic kd, input logic tk);
    rst = r; key_valid = kv; last_change = lc; key_down = kd; tick = tk;
    @(posedge clk);
    model(r, kv, lc, kd, tk);
    #1;
    chk("cur_dir", cur_dir, m_dir);
    chk("step", step, m_step);
    chk("state", state, m_state);
    chk("q_count", q_count, mq.size());
    chk("overflow", overflow, m_ovf);
    rst = 0; key_valid = 0; last_change = '0; key_down = 0; tick = 0;
  endtask

  task automatic key(input logic [8:0] c);
    cyc(0, 1, c, 1, 0);
  endtask

  task automatic tk();
    cyc(0, 0, 9'h000, 0, 1);
  endtask

  initial begin
    logic [7:0] codes [6] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h00};
    logic [8:0] lc;
    cyc(1, 0, 9'h000, 0, 0);
    chk("reset_all", {cur_dir, step, state, q_count, overflow}, 0);
    key(9'h023);
    chk("d_state_run", state, 1);
    chk("d_qcount", q_count, 1);
    tk();
    chk("d_tick_dir", cur_dir, 3);
    chk("d_tick_step", step, 1);
    chk("d_tick_q", q_count, 0);
    cyc(0, 0, 9'h000, 0, 0);
    chk("step_single", step, 0);
    key(9'h01D); key(9'h01C); key(9'h01B); key(9'h023);
    chk("full_q", q_count, 4);
    chk("no_ovf_yet", overflow, 0);
    key(9'h01D);
    chk("ovf_q", q_count, 4);
    chk("ovf_set", overflow, 1);
    cyc(0, 1, 9'h01D, 1, 1);
    chk("full_pushpop_q", q_count, 4);
    chk("full_pushpop_dir", cur_dir, 0);
    repeat (4) tk();
    chk("drain_dir", cur_dir, 0);
    chk("ovf_sticky", overflow, 1);
    key(9'h01B);
    tk();
    chk("rev_dir", cur_dir, BLK ? 0 : 1);
    chk("rev_step", step, 1);
    cyc(0, 1, 9'h01D, 0, 0);
    cyc(0, 1, 9'h11D, 1, 0);
    key(9'h01C); key(9'h01C);
    chk("filter_q", q_count, 1);
    key(9'h029);
    repeat (3) tk();
    chk("paused_state", state, 2);
    chk("paused_step", step, 0);
    chk("paused_q", q_count, 1);
    key(9'h029);
    chk("resume_state", state, 1);
    tk();
    chk("resume_dir", cur_dir, 2);
    chk("resume_step", step, 1);
    chk("resume_q", q_count, 0);
    key(9'h01D); tk();
    chk("pre35_dir", cur_dir, 0);
    cyc(0, 1, 9'h01C, 1, 1);
    chk("coinc_step", step, 1);
    chk("coinc_dir", cur_dir, 0);
    chk("coinc_q", q_count, 1);
    cyc(1, 1, 9'h023, 1, 1);
    chk("rst_all", {cur_dir, step, state, q_count, overflow}, 0);
    key(9'h023); tk();
    chk("no_stale_dir", cur_dir, 3);
    chk("no_stale_q", q_count, 0);
    repeat (400) begin
      lc = {($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, codes[$urandom_range(0, 5)]};
      cyc(0, 1'($urandom_range(0, 1)), lc, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter: QDEPTH, default 4, command queue depth; power of two, minimum 2.
REQ-002 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: key_valid  in  1  one-cycle pulse; last_change and key_down are valid this cycle.
REQ-005 Port: last_change  in  9  scan code from the keyboard decoder; bit 8 = extended flag, bits 7:0 = code.
REQ-006 Port: key_down  in  1  1 = make event, 0 = break event.
REQ-007 Port: tick  in  1  one-cycle game-step pulse.
REQ-008 Port: cur_dir  out  2  applied direction: 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT.
REQ-009 Port: step  out  1  one-cycle pulse per serviced tick.
REQ-010 Port: state  out  2  0 = IDLE, 1 = RUN, 2 = PAUSED.
REQ-011 Port: q_count  out  clog2(QDEPTH)+1  number of queued commands.
REQ-012 Port: overflow  out  1  sticky flag; set when a command is dropped because the queue is full.

Function
REQ-013 Accepted event: key_valid=1, key_down=1 and last_change[8]=0; all other events are ignored.
REQ-014 Direction decode: 0x1D -> 0 (W), 0x1B -> 1 (S), 0x1C -> 2 (A), 0x23 -> 3 (D); code 0x29 (space) = pause key; all other codes are ignored.
REQ-015 Duplicate filter: a direction equal to the queue tail (or to cur_dir when the queue is empty) is not enqueued.
REQ-016 Push: a filtered direction enters the FIFO tail with q_count incremented at the next edge.
REQ-017 Overflow: push to a full queue with no same-cycle pop drops the command and sets overflow; the queue is unchanged.
REQ-018 Same-cycle push and pop are both performed, including when the queue is full; q_count is unchanged and overflow is not set.
REQ-019 IDLE: tick is ignored; the first accepted direction is enqueued and the state becomes RUN at the same edge; space is ignored.
REQ-020 RUN, tick at cycle t: step=1 at t+1; if the queue was non-empty at t, the head is popped and applied to cur_dir at t+1.
REQ-021 Pop decisions use the queue contents before the edge; a key arriving in the same cycle as the tick is never applied by that tick.
REQ-022 RUN, space: the state becomes PAUSED at the next edge; a same-cycle tick is still serviced per REQ-020.
REQ-023 PAUSED: ticks are ignored (step=0, no pop); direction keys are still enqueued; space returns the state to RUN.
REQ-024 Latency from tick to step and cur_dir update is exactly 1 cycle; step is never asserted in two consecutive cycles unless tick is.

Reset
REQ-025 When rst=1 at an edge: state=IDLE, cur_dir=0, step=0, q_count=0, overflow=0, and the queue pointers are cleared.
REQ-026 rst takes priority over every same-cycle event; a key or tick coincident with rst is lost.
REQ-027 Reset mid-operation discards all queued commands; no stale entry is popped afterwards.

Configuration
REQ-028 Macro: KEY_CMD_REVERSE_BLOCK_EN.
REQ-029 Defined: a popped direction that is the opposite of cur_dir (UP/DOWN, LEFT/RIGHT) is discarded; cur_dir is held; step still pulses.
REQ-030 Undefined: every popped direction is applied to cur_dir unconditionally.

Verification
REQ-031 Reset, then key D (0x023, make), then tick -> state RUN after key; 1 cycle after tick: cur_dir=3, step=1, q_count=0.
REQ-032 In RUN with cur_dir=3, push W, A, S, D, then W (QDEPTH=4, no tick) -> q_count=4, fifth key dropped, overflow=1 until rst.
REQ-033 cur_dir=0 (UP), push S, tick -> with macro defined cur_dir stays 0 and step=1; without macro cur_dir=1.
REQ-034 RUN: space then 3 ticks -> state=PAUSED, step=0, q_count constant; space again then tick -> RUN, head popped, step=1.
REQ-035 Push A coincident with tick on an empty queue -> step=1, cur_dir unchanged, q_count=1 afterwards; rst next cycle -> all outputs at reset values.
REQ-036 Break codes (key_down=0), extended 0x11D, and code 0x1C sent twice -> only one entry (2) is queued.
